// File: rtl/fetch_pkg.sv
// Shared types and constants for the PC fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

  localparam int          INSTR_BYTES          = 4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0040_0000;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats load, load beats free, otherwise hold.
module if_id_reg #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              load,
  input  logic              free,
  input  logic [DATA_W-1:0] new_instr,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic [ADDR_W-1:0] new_pcp4,
  output logic              valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pcp4
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
      pcp4  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= new_instr;
      pc    <= new_pc;
      pcp4  <= new_pcp4;
    end else if (free) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and single-outstanding instruction fetch feeding IF/ID.
// Optional alignment check on redirect targets under PC_MISALIGN_CHECK_EN.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter int                DATA_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEFAULT_RESET_VECTOR)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pcp4,
`ifdef PC_MISALIGN_CHECK_EN
  output logic              misalign,
`endif
  output fetch_state_t      state
);

  // Handshake: a request is accepted on a rising edge where imem_req && imem_ready;
  // exactly one imem_rvalid follows, no earlier than the cycle after the accept.

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, req_pc_q, req_pcp4, target;
  logic              accept, load, free, halt;

  assign req_pcp4  = req_pc_q + ADDR_W'(INSTR_BYTES);
  assign imem_addr = pc_q;
  assign state     = state_q;
  assign accept    = imem_req && imem_ready;
  assign free      = if_valid && !stall;

`ifdef PC_MISALIGN_CHECK_EN
  logic misalign_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      misalign_q <= 1'b0;
    else if (redirect && (redirect_pc[1:0] != 2'b00))
      misalign_q <= 1'b1;
  end

  assign target   = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign halt     = misalign_q;
  assign misalign = misalign_q;
`else
  assign target = redirect_pc;
  assign halt   = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    imem_req = 1'b0;
    load     = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req = (!if_valid || !stall) && !redirect && !halt && !reset;
        if (imem_req && imem_ready) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_d = FETCH;
          if (!redirect) begin
            load = 1'b1;
            pc_d = req_pcp4;
          end
        end else if (redirect) begin
          state_d = DROP;
        end
      end
      // The dropped response is still owed by memory; wait it out even across redirects.
      DROP: begin
        if (imem_rvalid) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
    if (redirect) pc_d = target;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= FETCH;
      pc_q     <= RESET_VECTOR;
      req_pc_q <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (accept) req_pc_q <= pc_q;
    end
  end

  if_id_reg #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_if_id (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect),
    .load     (load),
    .free     (free),
    .new_instr(imem_rdata),
    .new_pc   (req_pc_q),
    .new_pcp4 (req_pcp4),
    .valid    (if_valid),
    .instr    (if_instr),
    .pc       (if_pc),
    .pcp4     (if_pcp4)
  );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed plus random bench for pc_fetch_unit with a transaction-level fetch model.
module tb_pc_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RV = 32'h0040_0000;

  logic         clk, reset, redirect, stall, imem_ready, imem_rvalid;
  logic [31:0]  redirect_pc, imem_rdata;
  logic         imem_req, if_valid;
  logic [31:0]  imem_addr, if_instr, if_pc, if_pcp4;
  fetch_state_t dbg_state;
`ifdef PC_MISALIGN_CHECK_EN
  logic         misalign;
`endif

  pc_fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_pcp4    (if_pcp4),
`ifdef PC_MISALIGN_CHECK_EN
    .misalign   (misalign),
`endif
    .state      (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: fetch address, one outstanding transaction, IF/ID contents.
  logic [31:0] m_pc, m_req_addr, m_instr, m_ifpc;
  bit          m_valid, m_out, m_drop, m_mis;
  // Memory model: one pending response with a countdown, optional directed data.
  bit          mem_pending;
  int          mem_cnt, lat_min, lat_max;
  logic [31:0] dq[$];
  logic        obs_req;
  logic [31:0] obs_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RV; m_valid = 0; m_out = 0; m_drop = 0; m_mis = 0;
  endtask

  // One clock cycle: drive inputs after negedge, check, update the model, advance.
  task automatic step(input bit rd, input logic [31:0] rpc, input bit st, input bit rdy);
    bit          rv, acc, ld, exp_req;
    logic [31:0] rdat;
    rv   = mem_pending && (mem_cnt == 0);
    rdat = $urandom;
    if (rv && dq.size() > 0) rdat = dq.pop_front();
    redirect    = rd;
    redirect_pc = rpc;
    stall       = st;
    imem_ready  = rdy;
    imem_rvalid = rv;
    imem_rdata  = rdat;
    #1;
    exp_req = !m_out && (!m_valid || !st) && !rd && !m_mis;
    chk("req", imem_req, exp_req);
    chk("addr", imem_addr, m_pc);
    chk("valid", if_valid, m_valid);
    if (m_valid) begin
      chk("instr", if_instr, m_instr);
      chk("pc", if_pc, m_ifpc);
      chk("pcp4", if_pcp4, m_ifpc + 32'd4);
    end
`ifdef PC_MISALIGN_CHECK_EN
    chk("misalign", misalign, m_mis);
`endif
    obs_req  = imem_req;
    obs_addr = imem_addr;
    acc = exp_req && rdy;
    ld  = m_out && rv && !m_drop && !rd;
    if (rd) m_valid = 0;
    else if (ld) begin m_valid = 1; m_instr = rdat; m_ifpc = m_req_addr; end
    else if (m_valid && !st) m_valid = 0;
    if (rd) begin
`ifdef PC_MISALIGN_CHECK_EN
      m_pc = rpc & 32'hFFFF_FFFC;
      if (rpc[1:0] != 2'b00) m_mis = 1;
`else
      m_pc = rpc;
`endif
    end else if (ld) m_pc = m_req_addr + 32'd4;
    if (m_out && rv) begin m_out = 0; m_drop = 0; end
    else if (m_out && rd) m_drop = 1;
    if (acc) begin m_out = 1; m_drop = 0; m_req_addr = imem_addr; end
    if (rv) mem_pending = 0;
    else if (mem_pending) mem_cnt--;
    if (acc) begin mem_pending = 1; mem_cnt = $urandom_range(lat_max, lat_min) - 1; end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_until_valid();
    for (int i = 0; i < 20; i++) begin
      step(0, 32'd0, 0, 1);
      if (m_valid) break;
    end
    chk("wait_valid", if_valid, 1);
  endtask

  initial begin
    reset = 1; redirect = 0; redirect_pc = 0; stall = 0;
    imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;
    mem_pending = 0; mem_cnt = 0; lat_min = 1; lat_max = 1;
    model_reset();

    repeat (3) @(negedge clk);
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, RV);
    chk("rst_valid", if_valid, 0);
    chk("rst_instr", if_instr, 0);
    chk("rst_pc", if_pc, 0);
    chk("rst_pcp4", if_pcp4, 0);
    chk("rst_state", dbg_state, FETCH);
    reset = 0;
    #1;
    chk("rel_req", imem_req, 1);
    chk("rel_addr", imem_addr, RV);
    @(negedge clk);

    // Sequential fetch with single-cycle latency.
    dq.push_back(32'hA); dq.push_back(32'hB); dq.push_back(32'hC);
    for (int k = 0; k < 3; k++) begin
      run_until_valid();
      chk("seq_pc", if_pc, RV + 32'(4 * k));
      chk("seq_pcp4", if_pcp4, RV + 32'(4 * k + 4));
      chk("seq_instr", if_instr, 32'hA + 32'(k));
    end

    // Decode stall holds IF/ID and blocks requests.
    for (int k = 0; k < 3; k++) begin
      step(0, 32'd0, 1, 1);
      chk("stall_req", obs_req, 0);
      chk("stall_pc", if_pc, RV + 32'h8);
      chk("stall_instr", if_instr, 32'hC);
    end
    lat_min = 2; lat_max = 2;
    step(0, 32'd0, 0, 1);
    chk("unstall_req", obs_req, 1);
    chk("unstall_addr", obs_addr, RV + 32'hC);

    // Redirect while waiting; the late word must be dropped.
    step(1, 32'h0040_0100, 0, 1);
    chk("redir_state", dbg_state, DROP);
    step(0, 32'd0, 0, 1);
    chk("drop_valid", if_valid, 0);
    step(0, 32'd0, 0, 1);
    chk("redir_req", obs_req, 1);
    chk("redir_addr", obs_addr, 32'h0040_0100);
    run_until_valid();
    chk("redir_pc", if_pc, 32'h0040_0100);
    chk("redir_pcp4", if_pcp4, 32'h0040_0104);

    // Redirect coinciding with rvalid and stall: flush wins, then wrap.
    lat_min = 1; lat_max = 1;
    step(0, 32'd0, 0, 1);
    step(1, 32'hFFFF_FFFC, 1, 1);
    chk("flush_valid", if_valid, 0);
    chk("flush_state", dbg_state, FETCH);
    chk("flush_addr", imem_addr, 32'hFFFF_FFFC);
    run_until_valid();
    chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap_pcp4", if_pcp4, 32'h0000_0000);
    step(0, 32'd0, 0, 1);
    chk("wrap_addr", obs_addr, 32'h0000_0000);
    run_until_valid();

    // Asynchronous reset mid-cycle clears IF/ID at once.
    #2 reset = 1;
    #1;
    chk("async_valid", if_valid, 0);
    chk("async_req", imem_req, 0);
    chk("async_addr", imem_addr, RV);
    @(negedge clk);
    reset = 0;
    model_reset();

    // Reset during WAIT; the stale response arrives in FETCH and is ignored.
    lat_min = 3; lat_max = 3;
    step(0, 32'd0, 0, 1);
    chk("late_state0", dbg_state, WAIT);
    #2 reset = 1;
    @(negedge clk);
    reset = 0;
    model_reset();
    repeat (3) step(0, 32'd0, 0, 0);
    chk("late_valid", if_valid, 0);
    chk("late_state", dbg_state, FETCH);
    lat_min = 1; lat_max = 3;
    run_until_valid();
    chk("late_pc", if_pc, RV);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      step($urandom_range(9) == 0, rpc, $urandom_range(2) == 0, $urandom_range(3) != 0);
    end

`ifdef PC_MISALIGN_CHECK_EN
    step(1, 32'h0040_0102, 0, 1);
    chk("mis_flag", misalign, 1);
    chk("mis_addr", imem_addr, 32'h0040_0100);
    for (int k = 0; k < 6; k++) begin
      step(0, 32'd0, 0, 1);
      chk("mis_req", obs_req, 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Owns the program counter and fetches instructions from instruction memory.
- Consumes the next-PC redirect produced by branch control (taken/jump/JR target) and feeds the IF/ID register with instruction, PC and PC+4.
- Supports one outstanding memory request, decode-side stall, and redirect-driven flush/drop of in-flight fetches.

Parameters:
- RESET_VECTOR, 32'h0040_0000: PC value loaded on reset.
- ADDR_W, 32: PC/address width.
- DATA_W, 32: instruction width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- redirect  in  1  non-sequential next PC this cycle (branch taken, JUMP or JR).
- redirect_pc  in  ADDR_W  next-PC target from branch control.
- stall  in  1  decode cannot accept; hold IF/ID outputs.
- imem_req  out  1  request valid to instruction memory.
- imem_addr  out  ADDR_W  fetch address; always equals current PC.
- imem_ready  in  1  memory accepts request this cycle (req && ready = accept).
- imem_rvalid  in  1  read data valid; exactly one per accepted request, at least 1 cycle after accept.
- imem_rdata  in  DATA_W  instruction word.
- if_valid  out  1  IF/ID holds a valid instruction.
- if_instr  out  DATA_W  fetched instruction.
- if_pc  out  ADDR_W  address of if_instr.
- if_pcp4  out  ADDR_W  if_pc + 4, modulo 2^ADDR_W.

Behaviour:
- Reset, asynchronous: pc=RESET_VECTOR, state=FETCH, imem_req=0 while reset is high, if_valid=0, if_instr=0, if_pc=0, if_pcp4=0.
- imem_req is a registered-state decode. It asserts in the first cycle after reset release.
- States:
  - FETCH: imem_req = (!if_valid || !stall) && !redirect. On accept go to WAIT and latch req_pc=pc.
  - WAIT: imem_req=0. On imem_rvalid load IF/ID: if_instr=rdata, if_pc=req_pc, if_pcp4=req_pc+4, if_valid=1. Then pc<=req_pc+4 and go to FETCH.
  - DROP: imem_req=0. On imem_rvalid discard data, leave IF/ID unchanged, go to FETCH.
- Redirect takes priority over everything:
  - pc<=redirect_pc and if_valid<=0 (flush) in the same edge, regardless of stall.
  - In WAIT without a same-cycle rvalid, go to DROP.
  - In WAIT with a same-cycle rvalid, discard the data and go to FETCH.
  - In FETCH, no request is issued that cycle.
  - In DROP, stay in DROP; pc is updated.
- Stall with if_valid=1: IF/ID is held bit-exact and FETCH issues no request. Stall with if_valid=0 is ignored.
- IF/ID is freed at an edge when if_valid && !stall. If no new rvalid arrives that edge, if_valid<=0.
- Best-case throughput is one instruction per 2 cycles (single outstanding request).
- PC wrap: 32'hFFFF_FFFC + 4 = 0. No fault is raised.
- A reset asserted mid-WAIT/DROP returns to FETCH. A late rvalid for the aborted request, arriving in FETCH, is ignored.

Optional Feature:
- Macro: PC_MISALIGN_CHECK_EN.
- With the macro defined:
  - Adds output misalign (1 bit).
  - A redirect with redirect_pc[1:0]!=0 sets misalign=1, sticky until reset.
  - pc still loads redirect_pc with bits [1:0] forced to 00.
  - FETCH holds imem_req=0 while misalign=1.
- Without the macro: no port, no check; redirect_pc[1:0] is passed through unmodified.

Decomposition:
- Package fetch_pkg holds:
  - fetch_state_t enum {FETCH, WAIT, DROP}.
  - INSTR_BYTES=4.
  - Default RESET_VECTOR constant.
- One sub-module, if_id_reg: holds valid/instr/pc/pcp4 with load, hold and flush controls, priority flush > load > hold.

Test Plan:
- Reset release: first cycle imem_req=1, imem_addr=32'h0040_0000, if_valid=0. Asserting reset mid-cycle immediately drives if_valid=0.
- Sequential fetch, memory ready=1, rvalid 1 cycle after accept, data 0xA,0xB,0xC:
  - if_pc = 0x00400000, 0x00400004, 0x00400008 in turn.
  - if_pcp4 = if_pc + 4.
  - if_instr matches the data.
- Stall 3 cycles with if_valid=1: if_instr/if_pc held constant and imem_req=0 all 3 cycles. After stall drop, the next request goes out at 0x0040000C.
- Redirect to 0x00400100 while in WAIT, rvalid 2 cycles later:
  - Returned word is dropped and if_valid=0.
  - Next imem_addr=0x00400100.
  - Next if_pc=0x00400100, if_pcp4=0x00400104.
- Redirect coinciding with rvalid and stall=1: flush wins; if_valid=0 and the data is discarded. Redirect to 0xFFFFFFFC then fetch: if_pcp4=0x00000000 and the next addr is 0.
- With PC_MISALIGN_CHECK_EN: redirect_pc=0x00400102 gives misalign=1, pc=0x00400100 and no further imem_req until reset.
